// File: rtl/mem_bus_pkg.sv
// Shared types, default widths and sizing helper for the memory-bus arbiter.
package mem_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_NUM_CH  = 2;
  localparam int DEF_TIMEOUT = 16;

  // Ceiling log2, never less than one bit so single-entry indices stay legal.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter: one-hot grant, either fixed priority (lowest index first)
// or round-robin starting at a pointer that advances past each taken grant.
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int RR_MODE = 0,
  localparam int IDX_W  = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              grant_take,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] start;
  logic             found;

  // Two passes: indices at/after the start point first, then the wrap-around part.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    start     = (RR_MODE != 0) ? ptr_q : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= start)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (IDX_W'(i) < start)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  // Pointer moves to the channel after the one just granted, wrapping at NUM_CH.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_take) begin
      ptr_d = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Multi-channel memory-bus request unit: arbitrates NUM_CH requesters onto
// one shared bus, one transaction at a time, with a bus acknowledge timeout.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        err,
  output logic [DATA_W-1:0]        rdata,
  output logic [NUM_CH-1:0]        busy,
  output logic                     bus_read,
  output logic                     bus_write,
  output logic [ADDR_W-1:0]        address_out,
  output logic [DATA_W-1:0]        data_out_BUS,
  input  logic [DATA_W-1:0]        data_in_BUS,
  input  logic                     bus_full
);

  localparam int IDX_W = clog2_min1(NUM_CH);
  localparam int CNT_W = clog2_min1(TIMEOUT);

  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_take;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant_take (grant_take),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Owner kept one-hot so done/err are a straight copy of it.
  logic [NUM_CH-1:0] owner_q, owner_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Next-state and registered-output logic; IDLE takes a grant, BUSY waits for ack or timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    done_d     = '0;
    err_d      = '0;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rdata_d    = rdata_q;
    grant_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_take = 1'b1;
          owner_d    = grant;
          rd_d       = ~we[grant_idx];
          wr_d       = we[grant_idx];
          addr_d     = addr_arr[grant_idx];
          dout_d     = wdata_arr[grant_idx];
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (bus_full) begin
          if (!wr_q) begin
            rdata_d = data_in_BUS;
          end
          done_d  = owner_q;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_d  = owner_q;
          err_d   = owner_q;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign bus_read     = rd_q;
  assign bus_write    = wr_q;
  assign address_out  = addr_q;
  assign data_out_BUS = dout_q;
  assign busy         = req & ~done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for two arbiter configurations (2ch fixed priority, 3ch
// round-robin) checked cycle by cycle against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXC = 3;
  localparam int NCYC = 2400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [MAXC-1:0]    req_v   [2];
  logic [MAXC-1:0]    we_v    [2];
  logic [MAXC*AW-1:0] addr_v  [2];
  logic [MAXC*DW-1:0] wdata_v [2];
  logic [DW-1:0]      din_v   [2];
  logic               bfull_v [2];

  logic [1:0]    done_a, err_a, busy_a;
  logic [2:0]    done_b, err_b, busy_b;
  logic [DW-1:0] rdata_a, rdata_b, dout_a, dout_b;
  logic [AW-1:0] ao_a, ao_b;
  logic          rd_a, rd_b, wr_a, wr_b;

  mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(2), .RR_MODE(0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_v[0][1:0]), .we(we_v[0][1:0]),
    .addr(addr_v[0][2*AW-1:0]), .wdata(wdata_v[0][2*DW-1:0]),
    .done(done_a), .err(err_a), .rdata(rdata_a), .busy(busy_a),
    .bus_read(rd_a), .bus_write(wr_a), .address_out(ao_a), .data_out_BUS(dout_a),
    .data_in_BUS(din_v[0]), .bus_full(bfull_v[0])
  );

  mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(3), .RR_MODE(1), .TIMEOUT(6)) dut_b (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]),
    .done(done_b), .err(err_b), .rdata(rdata_b), .busy(busy_b),
    .bus_read(rd_b), .bus_write(wr_b), .address_out(ao_b), .data_out_BUS(dout_b),
    .data_in_BUS(din_v[1]), .bus_full(bfull_v[1])
  );

  logic [MAXC-1:0] done_w [2];
  logic [MAXC-1:0] err_w  [2];
  logic [MAXC-1:0] busy_w [2];
  logic            rd_w   [2];
  logic            wr_w   [2];
  logic [AW-1:0]   ao_w   [2];
  logic [DW-1:0]   do_w   [2];
  logic [DW-1:0]   rdat_w [2];

  assign done_w[0] = {1'b0, done_a};
  assign done_w[1] = done_b;
  assign err_w[0]  = {1'b0, err_a};
  assign err_w[1]  = err_b;
  assign busy_w[0] = {1'b0, busy_a};
  assign busy_w[1] = busy_b;
  assign rd_w[0]   = rd_a;
  assign rd_w[1]   = rd_b;
  assign wr_w[0]   = wr_a;
  assign wr_w[1]   = wr_b;
  assign ao_w[0]   = ao_a;
  assign ao_w[1]   = ao_b;
  assign do_w[0]   = dout_a;
  assign do_w[1]   = dout_b;
  assign rdat_w[0] = rdata_a;
  assign rdat_w[1] = rdata_b;

  // Per-instance configuration as seen by the model.
  int nch [2] = '{2, 3};
  int rrm [2] = '{0, 1};
  int tmo [2] = '{4, 6};

  // Transaction-level model state.
  int            m_busy  [2];
  int            m_owner [2];
  int            m_wait  [2];
  int            m_ptr   [2];
  logic          m_we    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_rdata [2];
  logic [MAXC-1:0] e_done [2];
  logic [MAXC-1:0] e_err  [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic finish_txn(input int k, input bit timed_out);
    e_done[k][m_owner[k]] = 1'b1;
    e_err[k][m_owner[k]]  = timed_out;
    m_busy[k] = 0;
    $display("txn u%0d ch%0d %s addr=%h data=%h%s", k, m_owner[k], m_we[k] ? "WR" : "RD",
             m_addr[k], m_we[k] ? m_wdata[k] : m_rdata[k], timed_out ? " timeout" : "");
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step(input int k);
    int w;
    int c;
    if (rst) begin
      m_busy[k]  = 0;
      m_ptr[k]   = 0;
      m_rdata[k] = '0;
      e_done[k]  = '0;
      e_err[k]   = '0;
    end else begin
      e_done[k] = '0;
      e_err[k]  = '0;
      if (m_busy[k] != 0) begin
        m_wait[k]++;
        if (bfull_v[k]) begin
          if (!m_we[k]) m_rdata[k] = din_v[k];
          finish_txn(k, 1'b0);
        end else if (m_wait[k] == tmo[k]) begin
          finish_txn(k, 1'b1);
        end
      end else begin
        w = -1;
        for (int j = 0; j < nch[k]; j++) begin
          c = (rrm[k] != 0) ? (m_ptr[k] + j) % nch[k] : j;
          if (w < 0 && req_v[k][c]) w = c;
        end
        if (w >= 0) begin
          m_ptr[k]   = (w + 1) % nch[k];
          m_busy[k]  = 1;
          m_owner[k] = w;
          m_wait[k]  = 0;
          m_we[k]    = we_v[k][w];
          m_addr[k]  = addr_v[k][w*AW +: AW];
          m_wdata[k] = wdata_v[k][w*DW +: DW];
        end
      end
    end
  endtask

  task automatic check_unit(input int k);
    logic exp_rd, exp_wr;
    exp_rd = (m_busy[k] != 0) && !m_we[k];
    exp_wr = (m_busy[k] != 0) && m_we[k];
    check_eq($sformatf("u%0d.done", k), 32'(done_w[k]), 32'(e_done[k]));
    check_eq($sformatf("u%0d.err", k), 32'(err_w[k]), 32'(e_err[k]));
    check_eq($sformatf("u%0d.bus_read", k), 32'(rd_w[k]), 32'(exp_rd));
    check_eq($sformatf("u%0d.bus_write", k), 32'(wr_w[k]), 32'(exp_wr));
    check_eq($sformatf("u%0d.busy", k), 32'(busy_w[k]), 32'(req_v[k] & ~e_done[k]));
    check_eq($sformatf("u%0d.rdata", k), rdat_w[k], m_rdata[k]);
    if (exp_rd || exp_wr) begin
      check_eq($sformatf("u%0d.address_out", k), ao_w[k], m_addr[k]);
    end
    if (exp_wr) begin
      check_eq($sformatf("u%0d.data_out_BUS", k), do_w[k], m_wdata[k]);
    end
  endtask

  // Requesters and bus responder; phase 0 mixed, 1 continuous contention, 2 slow bus.
  task automatic drive_unit(input int k, input int phase);
    bit raise;
    int ack_pct;
    for (int j = 0; j < nch[k]; j++) begin
      if (done_w[k][j] || !req_v[k][j]) begin
        if (phase == 1)        raise = 1'b1;
        else if (done_w[k][j]) raise = ($urandom_range(0, 1) == 0);
        else                   raise = ($urandom_range(0, 3) == 0);
        req_v[k][j] = raise;
        if (raise) begin
          we_v[k][j]              = 1'($urandom_range(0, 1));
          addr_v[k][j*AW +: AW]   = $urandom;
          wdata_v[k][j*DW +: DW]  = $urandom;
        end
      end else if (phase == 0 && $urandom_range(0, 60) == 0) begin
        req_v[k][j] = 1'b0;
      end
    end
    ack_pct = (phase == 2) ? 15 : 55;
    if (rd_w[k] || wr_w[k]) bfull_v[k] = ($urandom_range(0, 99) < ack_pct);
    else                    bfull_v[k] = ($urandom_range(0, 9) == 0);
    din_v[k] = $urandom;
  endtask

  initial begin
    int phase;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_v[k]   = '0;
      we_v[k]    = '0;
      addr_v[k]  = '0;
      wdata_v[k] = '0;
      din_v[k]   = '0;
      bfull_v[k] = 1'b0;
      m_busy[k]  = 0;
      m_owner[k] = 0;
      m_wait[k]  = 0;
      m_ptr[k]   = 0;
      m_we[k]    = 1'b0;
      m_addr[k]  = '0;
      m_wdata[k] = '0;
      m_rdata[k] = '0;
      e_done[k]  = '0;
      e_err[k]   = '0;
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      check_unit(0);
      check_unit(1);
      phase = (cyc / 400) % 3;
      rst = (cyc < 2) || (phase == 0 && $urandom_range(0, 249) == 0);
      drive_unit(0, phase);
      drive_unit(1, phase);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised memory-bus request unit between the CPU core's fetch/load/store requesters and the single shared memory bus (data_in_BUS / bus_full / data_out_BUS / address_out).
- Successor to the core's single-requester bus hookup: generalised to NUM_CH channels with selectable fixed-priority or round-robin arbitration, configurable widths, and a bus timeout with error reporting.
- One transaction outstanding at a time.

Parameters:
- DATA_W, 32, bus data width.
- ADDR_W, 32, bus address width.
- NUM_CH, 2, number of requesters (ch0 = instruction fetch by convention); range 1..8.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 16, max BUSY cycles waiting for bus_full before error; range 2..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_CH  per-channel request, level, held until done.
- we  in  NUM_CH  per-channel write enable (1 = store).
- addr  in  NUM_CH*ADDR_W  per-channel address, packed, ch0 in LSBs.
- wdata  in  NUM_CH*DATA_W  per-channel write data, packed.
- done  out  NUM_CH  one-cycle completion pulse for the owning channel.
- err  out  NUM_CH  one-cycle timeout flag, coincident with done.
- rdata  out  DATA_W  read data, valid when done is high.
- busy  out  NUM_CH  high while the channel has req high and has not received done (instr_wait analogue).
- bus_read  out  1  read strobe to memory bus.
- bus_write  out  1  write strobe to memory bus.
- address_out  out  ADDR_W  bus address.
- data_out_BUS  out  DATA_W  bus write data.
- data_in_BUS  in  DATA_W  bus read data.
- bus_full  in  1  bus acknowledge/data-valid, one or more cycles.

Behaviour:
- Reset: state = IDLE; done, err, bus_read, bus_write = 0; address_out, data_out_BUS, rdata = 0; timeout counter = 0; RR pointer = 0. A reset during BUSY aborts the transaction with no done.
- State IDLE:
  - If any req bit is set, the arbiter picks a winner. It latches the winner's index, we, addr and wdata into registers and moves to BUSY.
  - address_out, data_out_BUS and the strobes are registered, so they are driven starting the cycle after the req is sampled.
  - bus_full is ignored in IDLE.
- State BUSY:
  - bus_read = ~we_lat and bus_write = we_lat, held steady. Address and data are held.
  - Counter increments each cycle.
  - If bus_full = 1: capture data_in_BUS into rdata (reads only; writes leave rdata unchanged). Pulse done[owner] the next cycle, deassert the strobes, go to IDLE.
  - Else if the counter reaches TIMEOUT-1: pulse done[owner] and err[owner], deassert the strobes, go to IDLE. rdata is unchanged.
- Latency:
  - Minimum req→done is 3 cycles (req sampled at T0, strobe at T1, bus_full at T1, done at T2).
  - A new grant can be taken in the cycle done is pulsed, so back-to-back transactions have no idle bubble beyond IDLE.
- Arbitration:
  - Fixed mode: lowest set index wins.
  - RR mode: search starts at pointer, and after each grant to channel i the pointer becomes (i+1) mod NUM_CH.
  - Simultaneous requests: exactly one grant; losers stay busy.
- req dropped mid-BUSY: the transaction still completes and done still pulses.
- A requester must not change we/addr/wdata while busy; the latched copy is used regardless.
- busy[i] = req[i] & ~done[i] (combinational).
- Widths: counter is clog2(TIMEOUT) bits; index is clog2(NUM_CH) bits (min 1).

Decomposition:
- Package mem_bus_pkg:
  - state enum {IDLE, BUSY};
  - default width localparams;
  - function for clog2 with minimum 1.
- Sub-module rr_arbiter (NUM_CH, RR_MODE):
  - combinational one-hot grant from req and pointer;
  - registered pointer update on a grant_take strobe.

Test Plan:
- Single read, NUM_CH=2: ch1 req, addr=0x10, bus_full=1 one cycle after bus_read → done[1] pulse, rdata=data_in_BUS (0x00000001), address_out=0x10, no err.
- Single write: ch0 we=1, wdata=0xDEADBEEF → bus_write=1, data_out_BUS=0xDEADBEEF until bus_full, done[0], rdata unchanged.
- Contention, RR_MODE=0: ch0 and ch1 hold req continuously for 4 transactions → ch0 granted every time; ch1 busy throughout.
- Contention, RR_MODE=1, NUM_CH=3: all req high → grant order 0,1,2,0.
- Timeout, TIMEOUT=4: read with bus_full never asserted → done and err pulse together after 4 BUSY cycles, strobes drop, next request is accepted normally.
- Reset and idle noise: rst asserted mid-BUSY → strobes 0 next cycle, no done. bus_full pulsed in IDLE → no done, no state change.
